// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator: FSM state encoding,
// key_code field layout and small helpers used by the top level.
package keypad_pkg;

  localparam int KEY_ROW_W   = 2;
  localparam int KEY_COL_W   = 2;
  localparam int KEY_CODE_W  = KEY_ROW_W + KEY_COL_W;
  localparam int KEY_ROW_LSB = KEY_COL_W;
  localparam int KEY_COL_LSB = 0;
  localparam int LINE_CNT    = 1 << KEY_ROW_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Width of a counter that must reach max(hold, gap) without wrapping.
  function automatic int cnt_width(input int hold, input int gap);
    int mx;
    mx = (hold > gap) ? hold : gap;
    return $clog2(mx + 1);
  endfunction

  // Closed-switch model: the captured row returns the captured column strobe.
  function automatic logic [LINE_CNT-1:0] row_drive(
    input logic [KEY_ROW_W-1:0] row,
    input logic [KEY_COL_W-1:0] col,
    input logic [LINE_CNT-1:0]  cols
  );
    logic [LINE_CNT-1:0] r;
    r      = '0;
    r[row] = cols[col];
    return r;
  endfunction

endpackage

// File: rtl/keypad_hold_timer.sv
// Phase timer for the keypad emulator: cleared by load, counts up once per
// cycle, saturates at all-ones instead of wrapping, and flags the last cycle
// of the current phase on tc.
module keypad_hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] last_value,
  output logic [W-1:0] count,
  output logic         tc
);

  // Count cycles since the last load; hold at all-ones so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last_value);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: accepts a key code, then closes the emulated switch
// (row returns follow the matching column strobe) for HOLD_CYCLES cycles,
// releases it for GAP_CYCLES cycles, pulses done and goes idle again.
// Optional build macro KEYPAD_BOUNCE_EN adds contact bounce at the start
// of each press (rows forced low on odd counter values inside the window).
//
// Handshake: a request transfers on a cycle where key_valid && key_ready.
// key_ready is high only in IDLE outside reset; a requester that sees
// key_ready low keeps key_valid and key_code stable until it transfers.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1024,
  parameter int GAP_CYCLES    = 256,
  parameter int BOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_ready,
  input  logic [LINE_CNT-1:0]   cols,
  output logic [LINE_CNT-1:0]   rows,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            fsm_state,
  output logic [cnt_width(HOLD_CYCLES, GAP_CYCLES)-1:0] timer_count
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] PRESS = ST_PRESS;
  localparam logic [1:0] GAP   = ST_GAP;

  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("keypad_emulator: HOLD_CYCLES, GAP_CYCLES and BOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [KEY_CODE_W-1:0] cap_code;
  logic [CNT_W-1:0]      count;
  logic                  tc;
  logic                  load;
  logic [CNT_W-1:0]      last_value;
  logic                  handshake;
  logic [LINE_CNT-1:0]   press_rows;

  assign key_ready = (state == IDLE) && rst;
  assign handshake = key_valid && key_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == GAP) && tc && rst;
  assign fsm_state = state;

  // Next-state decision: each phase ends on the timer's terminal count.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (handshake) state_next = PRESS;
      PRESS:   if (tc)        state_next = GAP;
      GAP:     if (tc)        state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the requested key on the handshake only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_code <= '0;
    end else if (handshake) begin
      cap_code <= key_code;
    end
  end

  // Timer restarts on every state entry and is held clear while idle.
  assign load       = (state == IDLE) || (state_next != state);
  assign last_value = (state == GAP) ? GAP_LAST : HOLD_LAST;

  keypad_hold_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .last_value (last_value),
    .count      (count),
    .tc         (tc)
  );

  assign timer_count = count;

`ifdef KEYPAD_BOUNCE_EN
  localparam int BOUNCE_LEN = (BOUNCE_CYCLES < HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  logic bounce_open;
  assign bounce_open = (int'(count) < BOUNCE_LEN) && count[0];
  assign press_rows  = bounce_open ? '0 :
                       row_drive(cap_code[KEY_ROW_LSB +: KEY_ROW_W],
                                 cap_code[KEY_COL_LSB +: KEY_COL_W], cols);
`else
  assign press_rows  = row_drive(cap_code[KEY_ROW_LSB +: KEY_ROW_W],
                                 cap_code[KEY_COL_LSB +: KEY_COL_W], cols);
`endif

  // Registered row returns: follow the switch while pressed, else released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows <= '0;
    end else if (state == PRESS) begin
      rows <= press_rows;
    end else begin
      rows <= '0;
    end
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024: number of clk cycles a key is held pressed; legal range is 1 or more.
REQ-002 Parameter GAP_CYCLES, default 256: number of released clk cycles after a press before the next key is accepted; legal range is 1 or more.
REQ-003 Parameter BOUNCE_CYCLES, default 16: length of the contact-bounce window at the start of a press; used only with KEYPAD_BOUNCE_EN.
REQ-004 clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 key_valid  in  1  a key press request is offered.
REQ-007 key_code  in  4  key to press: row = key_code[3:2], col = key_code[1:0].
REQ-008 key_ready  out  1  the emulator accepts a request this cycle.
REQ-009 cols  in  4  column strobes driven by the keyboard scanner, active-high.
REQ-010 rows  out  4  emulated row returns to the scanner, active-high.
REQ-011 busy  out  1  high while a press or gap is in progress.
REQ-012 done  out  1  one-cycle pulse marking the end of the gap.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, PRESS and GAP.
REQ-014 key_ready SHALL be 1 in IDLE only; a handshake occurs when key_valid and key_ready are both 1, which captures key_code and moves the FSM to PRESS on the next cycle.
REQ-015 key_code SHALL be ignored whenever no handshake occurs.
REQ-016 In PRESS, a registered output SHALL apply: rows[r] = cols[c] when r equals the captured row, else 0, where c is the captured column; latency from cols to rows is 1 cycle.
REQ-017 If cols is all-zero or has multiple bits set, the same rule SHALL apply bitwise with no error flag.
REQ-018 PRESS SHALL last exactly HOLD_CYCLES cycles, then the FSM SHALL move to GAP.
REQ-019 In GAP, rows SHALL be 0 for exactly GAP_CYCLES cycles.
REQ-020 On the last GAP cycle, done SHALL pulse for 1 cycle and the FSM SHALL return to IDLE.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 The cycle counter SHALL be $clog2(max(HOLD_CYCLES, GAP_CYCLES)+1) bits wide, SHALL clear on every state entry, and SHALL never wrap.
REQ-023 A request asserted during PRESS or GAP SHALL stall, held by the requester, until IDLE; it SHALL NOT be dropped or queued.

Reset
REQ-024 While rst is 0 at a clock edge, the block SHALL set state=IDLE, counter=0, rows=0, done=0, busy=0, the captured code=0, and key_ready=0 during that reset cycle.
REQ-025 Reset asserted mid-PRESS or mid-GAP SHALL abort the operation without a done pulse, and rows SHALL be 0 on the next cycle.
REQ-026 key_ready SHALL go to 1 on the first cycle after rst returns to 1.

Configuration
REQ-027 With KEYPAD_BOUNCE_EN defined, rows SHALL be forced to 0 on every odd counter value during the first min(BOUNCE_CYCLES, HOLD_CYCLES) cycles of PRESS, emulating contact bounce.
REQ-028 Without KEYPAD_BOUNCE_EN defined, no bounce logic SHALL be present and PRESS SHALL be clean; BOUNCE_CYCLES SHALL then be unused.

Structure
REQ-029 The shared package keypad_pkg SHALL hold the FSM state enum, the KEY_ROW_W/KEY_COL_W constants (2 and 2), and the key_code field positions.
REQ-030 The counter SHALL be a single sub-module keypad_hold_timer (load, terminal-count output), instantiated once.

Verification
REQ-031 With HOLD_CYCLES=8 and GAP_CYCLES=4, key_code=4'b0110 accepted and cols=4'b0100 held: rows=4'b0010 for 8 cycles starting 1 cycle after PRESS entry, then 0 for 4 cycles, done high on cycle 12, key_ready=1 on cycle 13.
REQ-032 During PRESS of code 4'b0110, a cols one-hot walk 0001→0010→0100→1000 SHALL yield rows 0000,0000,0010,0000, each delayed 1 cycle.
REQ-033 With key_valid held high and code 4'b1111 during the press of code 4'b0000, the second request SHALL be accepted only in the first IDLE cycle after done, and rows SHALL be 4'b1000 while cols=4'b1000.
REQ-034 With rst=0 at PRESS cycle 3, the next cycle SHALL show rows=0, busy=0, and no done pulse, and key_ready SHALL be 1 after release.
REQ-035 With KEYPAD_BOUNCE_EN, BOUNCE_CYCLES=4 and a matching column held, rows SHALL show 1,0,1,0 over PRESS cycles 0..3 and then stay steady at 1.
REQ-036 With HOLD_CYCLES=1 and GAP_CYCLES=1, the sequence IDLE→PRESS→GAP→IDLE SHALL take 2 busy cycles, with done on the GAP cycle.
